// File: rtl/upsampler_arbiter.sv
// Round-robin arbiter that shares one vector_upsampler among NUM_REQ producers.
// Launches one job at a time and returns a per-requester done or watchdog-timeout pulse.
module upsampler_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned INPUT_COUNT    = 128,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NUM_REQ-1:0]                         req_i,
    input  logic [NUM_REQ*DATA_WIDTH*INPUT_COUNT-1:0]  req_vector_i,
    output logic [NUM_REQ-1:0]                         grant_o,
    output logic [NUM_REQ-1:0]                         job_done_o,
    output logic [NUM_REQ-1:0]                         job_error_o,
    output logic                                       busy_o,
    output logic [7:0]                                 err_count_o,
    output logic                                       up_start_o,
    output logic [DATA_WIDTH*INPUT_COUNT-1:0]          up_vector_o,
    input  logic                                       up_busy_i,
    input  logic                                       up_done_i
);

    localparam int unsigned VecW = DATA_WIDTH * INPUT_COUNT;
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StRelease} state_e;

    state_e              state_q;
    logic [IdxW-1:0]     ptr_q;
    logic [IdxW-1:0]     owner_q;
    logic [WdW-1:0]      wd_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  done_q;
    logic [NUM_REQ-1:0]  error_q;
    logic                busy_q;
    logic [7:0]          err_q;
    logic                start_q;
    logic [VecW-1:0]     vec_q;

    logic                win_found;
    logic [IdxW-1:0]     win_idx;
    logic [IdxW-1:0]     cand;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [IdxW-1:0]     ptr_next;

    // Search starts at the pointer and wraps, so the last owner is favoured least.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        win_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % NUM_REQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_onehot[win_idx] = win_found;
        ptr_next = IdxW'((32'(owner_q) + 32'd1) % NUM_REQ);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            wd_q    <= '0;
            grant_q <= '0;
            done_q  <= '0;
            error_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= '0;
            start_q <= 1'b0;
            vec_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found && !up_busy_i) begin
                        grant_q <= win_onehot;
                        owner_q <= win_idx;
                        vec_q   <= req_vector_i[32'(win_idx)*VecW +: VecW];
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StLaunch;
                    end
                end
                StLaunch: begin
                    start_q <= 1'b0;
                    wd_q    <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    wd_q <= wd_q + WdW'(1);
                    // A done arriving on the last watchdog cycle still counts as success.
                    if (up_done_i) begin
                        done_q  <= grant_q;
                        grant_q <= '0;
                        state_q <= StRelease;
                    end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                        error_q <= grant_q;
                        grant_q <= '0;
                        if (err_q != 8'hFF) begin
                            err_q <= err_q + 8'd1;
                        end
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    ptr_q   <= ptr_next;
                    done_q  <= '0;
                    error_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign job_done_o  = done_q;
    assign job_error_o = error_q;
    assign busy_o      = busy_q;
    assign err_count_o = err_q;
    assign up_start_o  = start_q;
    assign up_vector_o = vec_q;

endmodule

// File: tb/tb_upsampler_arbiter.sv
// Randomized self-checking bench for upsampler_arbiter against a job-level reference model.
module tb_upsampler_arbiter;

    localparam int N  = 2;
    localparam int IC = 128;
    localparam int DW = 16;
    localparam int T  = 16;
    localparam int VW = DW * IC;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_l;
    logic [N*VW-1:0] req_vector;
    logic            up_busy, up_done, up_done_l;

    logic [N-1:0]    grant, job_done, job_error;
    logic            busy, up_start;
    logic [7:0]      err_count;
    logic [VW-1:0]   up_vector;

    logic [N-1:0]    grant_l, job_done_l, job_error_l;
    logic            busy_l, up_start_l;
    logic [7:0]      err_count_l;
    logic [VW-1:0]   up_vector_l;

    int n_checks = 0;
    int n_pass   = 0;
    int ptr_m    = 0;
    int err_m    = 0;

    always #5 clk = ~clk;

    upsampler_arbiter #(
        .NUM_REQ(N), .INPUT_COUNT(IC), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_vector_i(req_vector),
        .grant_o(grant), .job_done_o(job_done), .job_error_o(job_error),
        .busy_o(busy), .err_count_o(err_count), .up_start_o(up_start),
        .up_vector_o(up_vector), .up_busy_i(up_busy), .up_done_i(up_done)
    );

    upsampler_arbiter #(
        .NUM_REQ(N), .INPUT_COUNT(IC), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(1024)
    ) u_dut_long (
        .clk_i(clk), .rst_i(rst), .req_i(req_l), .req_vector_i(req_vector),
        .grant_o(grant_l), .job_done_o(job_done_l), .job_error_o(job_error_l),
        .busy_o(busy_l), .err_count_o(err_count_l), .up_start_o(up_start_l),
        .up_vector_o(up_vector_l), .up_busy_i(1'b0), .up_done_i(up_done_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic rand_vectors();
        for (int w = 0; w < N * VW / 32; w++) req_vector[w*32 +: 32] = $urandom();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_l = '0; up_busy = 1'b0; up_done = 1'b0; up_done_l = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ptr_m = 0;
        err_m = 0;
    endtask

    // One full job from the IDLE sampling edge to the return to IDLE.
    // lat = WAIT cycles before up_done rises; lat > T-1 means the upsampler never answers.
    task automatic run_job(input int lat, input logic [N-1:0] next_req, output int w);
        logic [N-1:0]  oh;
        logic [VW-1:0] ev;
        logic          is_err;
        int            endstep;
        w = -1;
        for (int i = 0; i < N; i++) begin
            if (w < 0 && req[(ptr_m + i) % N]) w = (ptr_m + i) % N;
        end
        if (w < 0) begin
            check("no_req", 0, 1);
            return;
        end
        oh = '0;
        oh[w] = 1'b1;
        ev = req_vector[w*VW +: VW];
        @(posedge clk); #1;
        check("grant", 32'(grant), 32'(oh));
        check("start", 32'(up_start), 1);
        check("busy", 32'(busy), 1);
        check("vec", 32'(up_vector == ev), 1);
        rand_vectors();
        up_done = 1'($urandom_range(0, 1));  // ignored outside WAIT
        @(posedge clk); #1;
        up_done = 1'b0;
        check("launch", 32'({grant, up_start}), 32'({oh, 1'b0}));
        is_err  = (lat < 0) || (lat > T - 1);
        endstep = is_err ? T : lat + 1;
        for (int s = 1; s <= endstep; s++) begin
            if (!is_err && s == lat + 1) up_done = 1'b1;
            @(posedge clk); #1;
            up_done = 1'b0;
            if (s < endstep)
                check("wait", 32'({grant, job_done, job_error, up_start}),
                      32'({oh, {N{1'b0}}, {N{1'b0}}, 1'b0}));
        end
        if (is_err && err_m < 255) err_m++;
        check("done", 32'(job_done), is_err ? 32'(0) : 32'(oh));
        check("error", 32'(job_error), is_err ? 32'(oh) : 32'(0));
        check("rel", 32'({grant, busy, up_start}), 32'(3'b010));
        check("errcnt", 32'(err_count), 32'(err_m));
        check("vec_hold", 32'(up_vector == ev), 1);
        req = next_req;
        up_done = 1'($urandom_range(0, 1));  // ignored outside WAIT
        @(posedge clk); #1;
        up_done = 1'b0;
        check("idle", 32'({grant, job_done, job_error, busy}), 0);
        ptr_m = (w + 1) % N;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            w, bad, starts, lat;
        logic [VW-1:0] pat;

        rand_vectors();
        rst = 1'b1; req = '0; req_l = '0; up_busy = 1'b0; up_done = 1'b0; up_done_l = 1'b0;
        #3;
        check("rst_ctl", 32'({grant, job_done, job_error, busy, up_start}), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_vec", 32'(up_vector == '0), 1);
        do_reset();

        // Long-latency job on the 1024-cycle instance.
        for (int j = 0; j < IC; j++) begin
            req_vector[j*DW +: DW] = DW'(j);
            pat[j*DW +: DW]        = DW'(j);
        end
        req_l = 2'b01;
        @(posedge clk); #1;
        check("l_grant", 32'(grant_l), 32'(2'b01));
        check("l_start", 32'(up_start_l), 1);
        check("l_vec", 32'(up_vector_l == pat), 1);
        bad = 0;
        starts = 0;
        for (int c = 1; c <= 785; c++) begin
            @(posedge clk); #1;
            starts += int'(up_start_l);
            if (job_done_l != 0 || job_error_l != 0 || grant_l != 2'b01) bad = 1;
        end
        up_done_l = 1'b1;
        check("l_early", bad, 0);
        check("l_starts", starts, 0);
        @(posedge clk); #1;
        up_done_l = 1'b0;
        check("l_done", 32'({job_done_l, job_error_l, grant_l, busy_l}), 32'(7'b01_00_00_1));
        req_l = '0;
        @(posedge clk); #1;
        check("l_idle", 32'({job_done_l, busy_l, err_count_l}), 0);

        // Both requesters held: alternating grants.
        do_reset();
        rand_vectors();
        req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            run_job($urandom_range(0, T - 2), 2'b11, w);
            check("rr_seq", w, j % 2);
        end

        // Done on the final watchdog cycle wins over the timeout.
        run_job(T - 1, 2'b10, w);

        // Upsampler busy stalls arbitration.
        req = 2'b10;
        up_busy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            check("stall", 32'({grant, up_start, busy}), 0);
        end
        up_busy = 1'b0;
        run_job(2, 2'b00, w);
        check("stall_w", w, 1);

        // Random request patterns, latencies and vectors.
        req = 2'($urandom_range(1, 3));
        for (int j = 0; j < 40; j++) begin
            lat = $urandom_range(0, T + 3);
            run_job(lat, 2'($urandom_range(1, 3)), w);
        end

        // Leave the pointer at 1, then reset asynchronously in the middle of WAIT.
        req = 2'b01;
        run_job(1, 2'b11, w);
        @(posedge clk); #1;
        check("pre_grant", 32'(grant), 32'(2'b10));
        @(posedge clk); #1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_ctl", 32'({grant, job_done, job_error, busy, up_start}), 0);
        check("arst_misc", 32'({err_count, 1'(up_vector == '0)}), 1);
        #1;
        rst = 1'b0;
        ptr_m = 0;
        err_m = 0;
        run_job(3, 2'b01, w);
        check("arst_w", w, 0);

        // Timeouts and err_count saturation.
        run_job(-1, 2'b01, w);
        check("err_one", 32'(err_count), 1);
        for (int j = 0; j < 256; j++) run_job(-1, 2'b01, w);
        check("err_sat", 32'(err_count), 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/upsampler_arbiter.md
Name: upsampler_arbiter

Overview:
Shares one vector_upsampler instance among NUM_REQ feature producers, for example the generator output and a test-pattern source. Each producer raises a request with its feature vector. The block picks one requester with round-robin arbitration, latches its vector, and issues a single start pulse. It then waits for the upsampler's done, or for a watchdog timeout, and returns a per-requester completion or error pulse. The block sits between the producers and the upsampler, and follows the pipeline's start/busy/done scheme.

Parameters:
NUM_REQ, 2, number of requesters (>=1).
INPUT_COUNT, 128, feature elements per vector (matches the upsampler).
DATA_WIDTH, 16, bits per element.
TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before the job is aborted (>=2).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  asynchronous reset, active-high.
req  input  NUM_REQ  request per requester; held high until that requester's job_done or job_error.
req_vector  input  NUM_REQ*DATA_WIDTH*INPUT_COUNT  vectors concatenated; requester i occupies slice i.
grant  output  NUM_REQ  one-hot owner of the upsampler; held for the whole job.
job_done  output  NUM_REQ  1-cycle pulse to the owner on successful completion.
job_error  output  NUM_REQ  1-cycle pulse to the owner on timeout.
busy  output  1  high in every state except IDLE.
err_count  output  8  count of timeouts; saturates at 255.
up_start  output  1  start to the upsampler; 1-cycle pulse.
up_vector  output  DATA_WIDTH*INPUT_COUNT  latched vector of the owner.
up_busy  input  1  upsampler busy.
up_done  input  1  upsampler done pulse.

Behaviour:
- Reset (asynchronous, any state): state=IDLE.
  - All outputs are 0: grant, job_done, job_error, busy, err_count, up_start, up_vector.
  - Round-robin pointer=0 and watchdog=0.
- States are IDLE, LAUNCH, WAIT and RELEASE. All outputs are registered.
- IDLE:
  - If req!=0 and up_busy=0, the winner is the first set bit at or above the pointer, wrapping modulo NUM_REQ.
  - On that edge: grant<=onehot(winner), up_vector<=slice(winner), up_start<=1, busy<=1, state<=LAUNCH.
  - If up_busy=1, the block stalls with no grant.
- LAUNCH (exactly 1 cycle):
  - up_start is high during this cycle only.
  - Next edge: up_start<=0, watchdog<=0, state<=WAIT.
- WAIT:
  - watchdog increments each cycle.
  - If up_done=1: job_done[owner]<=1, grant<=0, state<=RELEASE.
  - Otherwise, if watchdog==TIMEOUT_CYCLES-1: job_error[owner]<=1, grant<=0, err_count increments (saturating), state<=RELEASE.
  - If up_done coincides with the final watchdog cycle, done wins and there is no error.
- RELEASE (1 cycle):
  - job_done or job_error is high.
  - No arbitration happens in this cycle, so the requester can drop req before IDLE samples it.
  - Next edge: pointer<=(owner+1) mod NUM_REQ, pulses cleared, busy<=0, state<=IDLE.
- Latency: a request seen in IDLE gives grant and up_start 1 cycle later. job_done follows up_done by 1 cycle.
- up_done outside WAIT is ignored.
- Deasserting req mid-job does not abort the job.
- req_vector is sampled only on the grant edge; up_vector stays constant until the next grant.
- A requester whose req stays high after RELEASE is re-arbitrated, with the next requester favoured.
- NUM_REQ=1: the pointer stays 0.

Test Plan:
1. req=01 with a vector pattern 0x0000..0x007F; the upsampler model asserts up_done 785 cycles after start -> grant=01 and up_start pulses 1 cycle after req; up_vector matches the pattern; job_done[0] pulses 1 cycle after up_done; busy returns low 2 cycles after up_done.
2. req=11 held continuously from reset -> grant sequence is 01, 10, 01, 10; each job is separated by RELEASE plus one IDLE cycle; up_start fires exactly once per job.
3. TIMEOUT_CYCLES=16 and the model never raises done -> job_error[0] pulses 16 cycles after entering WAIT; err_count=1; no job_done. Repeating 256 times -> err_count stays at 255.
4. up_busy held high with req=10 -> no grant and up_start=0. Release up_busy -> grant=10 on the next edge.
5. Assert rst asynchronously mid-WAIT (no clock edge) -> all outputs are 0 immediately. After rst is released with req=11 -> grant=01, confirming the pointer reset to 0.
6. up_done arrives in the same cycle as watchdog=TIMEOUT_CYCLES-1 -> job_done pulses, job_error stays 0, err_count is unchanged.
